switch_input_debouncer: RTL and testbench
=========================================

// Module: switch_input_debouncer
// PURPOSE
//  Input-side counterpart of the board display path: samples the 10 raw slide switches and
//  synchronises them to clk. It debounces them as one vector and publishes a stable switch word.
//  It splits that word into the operand_1/operand_2/mode/on_off fields consumed by the mini ALU.
//  Each committed change is announced with a valid/ack handshake so downstream logic recomputes once per change.
// PARAMETERS
//  WIDTH            10      raw switch vector width (field split below requires 10)
//  DEBOUNCE_CYCLES  500000  cycles input must hold unchanged before commit (10 ms @ 50 MHz); legal >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  settle counter width (localparam, not overridable)
// PORTS
//  clk              in   1      system clock, all state on rising edge
//  rst_n            in   1      asynchronous active-low reset
//  switches_raw     in   WIDTH  asynchronous switch pins
//  switches_stable  out  WIDTH  last committed debounced vector
//  operand_1        out  4      switches_stable[9:6]
//  operand_2        out  4      switches_stable[5:2]
//  mode             out  1      switches_stable[1]
//  on_off           out  1      switches_stable[0]
//  update_valid     out  1      committed change pending, held until acked
//  update_ack       in   1      consumer accepts pending change
//  overrun          out  1      sticky: a commit occurred while update_valid already high
// BEHAVIOUR
//  Reset (async assert, sync release): sync0/sync1, cand, stable, cnt = 0; state STABLE.
//  Reset also clears update_valid and overrun. Field outputs are pure wires of stable, so all = 0.
//  Synchroniser: 2-FF chain sync0 <= raw; sync1 <= sync0. The FSM only sees sync1.
//  FSM states:
//   STABLE: if sync1 != stable -> cand <= sync1, cnt <= 0, go SETTLE; else stay.
//   SETTLE: if sync1 != cand -> cand <= sync1, cnt <= 0 (restart window), stay.
//           else if cnt == DEBOUNCE_CYCLES-1 -> go STABLE; if cand != stable: stable <= cand, commit event.
//           else cnt <= cnt+1.
//  Glitch that returns to the old value inside the window: cand == stable at expiry -> no commit, no valid.
//  Latency: raw step held steady from edge 0 -> stable/update_valid change at edge DEBOUNCE_CYCLES+3.
//  Handshake:
//   - commit sets update_valid at the same edge stable updates.
//   - update_ack sampled while update_valid=1 clears it next edge.
//   - ack while valid=0 is ignored.
//   - commit and ack in the same cycle: update_valid stays 1 (new change wins), overrun unchanged.
//   - commit while valid=1 and no ack: stable takes the newer value (coalesce), valid stays 1, overrun <= 1.
//   - overrun clears on an accepted ack with no simultaneous commit.
//  Whole-vector debounce: any bit changing restarts the window for all bits; no per-bit commits.
//  Reset mid-SETTLE: window aborted, pending cand discarded.
//  Non-zero switches at reset release commit normally as a first event after DEBOUNCE_CYCLES+3 cycles.
//  cnt never wraps: bounded by DEBOUNCE_CYCLES-1 compare.
// TESTING (DEBOUNCE_CYCLES=4)
//  1 reset with raw=10'h3FF, release, hold -> outputs 0 until edge 7 after release.
//    Then stable=3FF, operand_1=F, operand_2=F, mode=1, on_off=1, valid=1.
//  2 raw 000->10'b0101_0011_1_1, ack 2 cycles after valid -> operand_1=5, operand_2=3, mode=1, on_off=1.
//    Valid high exactly 3 cycles; overrun=0.
//  3 raw pulse 000->001 for 2 cycles then back to 000 -> no commit, valid never asserts, stable=000.
//  4 raw toggles every 3 cycles for 20 cycles then holds 10'h2A0 -> single commit 7 cycles after last toggle.
//  5 two committed changes (0x040 then 0x0C0) without ack -> stable=0x0C0, valid=1, overrun=1.
//    Ack -> valid=0, overrun=0.
//  6 assert rst_n=0 mid-SETTLE with valid=1 -> all outputs 0 immediately (async).
//    No commit of the aborted value until re-observed for a full window.

Source files
------------

// File: rtl/switch_input_debouncer.sv
// Slide-switch front end: 2-FF synchroniser, whole-vector debounce, field split
// and a valid/ack change notification for the mini ALU.
module switch_input_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches_stable,
    output logic [3:0]       operand_1,
    output logic [3:0]       operand_2,
    output logic             mode,
    output logic             on_off,
    output logic             update_valid,
    input  logic             update_ack,
    output logic             overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE,
        ST_SETTLE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   sync0;
    logic [WIDTH-1:0]   sync1;
    logic [WIDTH-1:0]   cand;
    logic [WIDTH-1:0]   cand_nx;
    logic [WIDTH-1:0]   stable;
    logic [WIDTH-1:0]   stable_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               commit;
    logic               valid;
    logic               valid_nx;
    logic               ovr;
    logic               ovr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= switches_raw;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_STABLE;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_nx;
            cand   <= cand_nx;
            stable <= stable_nx;
            cnt    <= cnt_nx;
            valid  <= valid_nx;
            ovr    <= ovr_nx;
        end
    end

    // Any bit moving restarts the window for the whole vector.
    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        stable_nx = stable;
        cnt_nx    = cnt;
        commit    = 1'b0;
        unique case (state)
            ST_STABLE: begin
                if (sync1 != stable) begin
                    cand_nx  = sync1;
                    cnt_nx   = '0;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sync1 != cand) begin
                    cand_nx = sync1;
                    cnt_nx  = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = ST_STABLE;
                    if (cand != stable) begin
                        stable_nx = cand;
                        commit    = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_STABLE;
            end
        endcase
    end

    // A fresh commit always wins over a same-cycle ack.
    always_comb begin
        valid_nx = valid;
        ovr_nx   = ovr;
        if (commit) begin
            valid_nx = 1'b1;
            if (valid && !update_ack) begin
                ovr_nx = 1'b1;
            end
        end else if (valid && update_ack) begin
            valid_nx = 1'b0;
            ovr_nx   = 1'b0;
        end
    end

    assign switches_stable = stable;
    assign operand_1       = stable[9:6];
    assign operand_2       = stable[5:2];
    assign mode            = stable[1];
    assign on_off          = stable[0];
    assign update_valid    = valid;
    assign overrun         = ovr;

endmodule

// File: tb/tb_switch_input_debouncer.sv
// Directed + randomized bench for switch_input_debouncer with a
// timestamp-based reference model of the debounce window and handshake.
module tb_switch_input_debouncer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] switches_raw;
    logic [9:0] switches_stable;
    logic [3:0] operand_1;
    logic [3:0] operand_2;
    logic       mode;
    logic       on_off;
    logic       update_valid;
    logic       update_ack;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [9:0] m_d0, m_d1, m_cand, m_stable;
    bit         m_settle, m_valid, m_ovr;
    int         m_start, cyc;

    switch_input_debouncer #(
        .WIDTH(10),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .switches_raw(switches_raw),
        .switches_stable(switches_stable),
        .operand_1(operand_1),
        .operand_2(operand_2),
        .mode(mode),
        .on_off(on_off),
        .update_valid(update_valid),
        .update_ack(update_ack),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d0 = '0; m_d1 = '0; m_cand = '0; m_stable = '0;
        m_settle = 0; m_valid = 0; m_ovr = 0; m_start = 0;
    endtask

    // One clock: sample inputs, advance the model, compare 1 time unit after the edge.
    task automatic tick();
        logic [9:0] r;
        logic a, rn, seen;
        bit commit;
        r = switches_raw; a = update_ack; rn = rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (!rn) begin
            model_reset();
        end else begin
            seen = 1'b0;
            commit = 0;
            if (m_settle) begin
                if (m_d1 != m_cand) begin
                    m_cand = m_d1; m_start = cyc;
                end else if (cyc - m_start == N) begin
                    m_settle = 0;
                    if (m_cand != m_stable) begin
                        m_stable = m_cand; commit = 1;
                    end
                end
            end else if (m_d1 != m_stable) begin
                m_settle = 1; m_cand = m_d1; m_start = cyc;
            end
            if (commit) begin
                if (m_valid && !a) m_ovr = 1;
                m_valid = 1;
            end else if (m_valid && a) begin
                m_valid = 0; m_ovr = 0;
            end
            m_d1 = m_d0; m_d0 = r;
            if (seen) m_d0 = r;
        end
        chk("stable", 32'(switches_stable), 32'(m_stable));
        chk("fields", 32'({operand_1, operand_2, mode, on_off}), 32'(m_stable));
        chk("valid", 32'(update_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!update_valid && k < 20) begin
            tick(); k++;
        end
        chk("wait_valid", 32'(update_valid), 32'd1);
    endtask

    task automatic do_ack();
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
    endtask

    initial begin
        int n;
        bit any_valid;
        cyc = 0;
        model_reset();
        update_ack = 1'b0;

        // 1: reset with all switches up, first commit 7 edges after release
        rst_n = 1'b0;
        switches_raw = 10'h3FF;
        tick(); tick();
        chk("t1_reset_stable", 32'(switches_stable), 32'h0);
        chk("t1_reset_valid", 32'(update_valid), 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        chk("t1_edge6_stable", 32'(switches_stable), 32'h0);
        tick();
        chk("t1_edge7_stable", 32'(switches_stable), 32'h3FF);
        chk("t1_op1", 32'(operand_1), 32'hF);
        chk("t1_op2", 32'(operand_2), 32'hF);
        chk("t1_mode_onoff", 32'({mode, on_off}), 32'h3);
        chk("t1_valid", 32'(update_valid), 32'h1);
        do_ack();

        // 2: clear to zero, then 0101_0011_1_1 with ack two cycles after valid
        switches_raw = 10'h000;
        wait_valid();
        do_ack();
        switches_raw = 10'b0101_0011_1_1;
        wait_valid();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            if (update_valid) n++;
            tick();
        end
        if (update_valid) n++;
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
        if (update_valid) n++;
        chk("t2_valid_cycles", 32'(n), 32'd3);
        chk("t2_op1", 32'(operand_1), 32'h5);
        chk("t2_op2", 32'(operand_2), 32'h3);
        chk("t2_mode_onoff", 32'({mode, on_off}), 32'h3);
        chk("t2_overrun", 32'(overrun), 32'h0);

        // 3: short glitch from zero must not commit
        switches_raw = 10'h000;
        wait_valid();
        do_ack();
        for (int i = 0; i < 8; i++) tick();
        switches_raw = 10'h001;
        tick(); tick();
        switches_raw = 10'h000;
        any_valid = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (update_valid) any_valid = 1;
        end
        chk("t3_no_valid", 32'(any_valid), 32'h0);
        chk("t3_stable", 32'(switches_stable), 32'h0);

        // 4: toggling faster than the window, then hold 2A0
        any_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) switches_raw = (switches_raw == 10'h155) ? 10'h0AA : 10'h155;
            tick();
            if (update_valid) any_valid = 1;
        end
        switches_raw = 10'h2A0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (update_valid) any_valid = 1;
        end
        chk("t4_no_early_commit", 32'(any_valid), 32'h0);
        tick();
        chk("t4_commit_edge7", 32'(update_valid), 32'h1);
        chk("t4_stable", 32'(switches_stable), 32'h2A0);
        do_ack();

        // 5: two commits without ack coalesce and flag overrun
        switches_raw = 10'h040;
        wait_valid();
        switches_raw = 10'h0C0;
        n = 0;
        while (switches_stable != 10'h0C0 && n < 20) begin
            tick(); n++;
        end
        chk("t5_stable", 32'(switches_stable), 32'h0C0);
        chk("t5_valid", 32'(update_valid), 32'h1);
        chk("t5_overrun", 32'(overrun), 32'h1);
        do_ack();
        chk("t5_ack_valid", 32'(update_valid), 32'h0);
        chk("t5_ack_overrun", 32'(overrun), 32'h0);

        // 6: async reset mid-window with valid pending
        switches_raw = 10'h100;
        wait_valid();
        switches_raw = 10'h200;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_async_stable", 32'(switches_stable), 32'h0);
        chk("t6_async_fields", 32'({operand_1, operand_2, mode, on_off}), 32'h0);
        chk("t6_async_valid", 32'(update_valid), 32'h0);
        chk("t6_async_overrun", 32'(overrun), 32'h0);
        tick();
        rst_n = 1'b1;
        any_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (update_valid) any_valid = 1;
        end
        chk("t6_no_early_commit", 32'(any_valid), 32'h0);
        tick();
        chk("t6_recommit", 32'(switches_stable), 32'h200);
        do_ack();

        // Randomized segments: arbitrary holds and random acks against the model
        for (int s = 0; s < 80; s++) begin
            int hold;
            if ($urandom_range(0, 2) == 0)
                switches_raw = switches_raw ^ (10'h001 << $urandom_range(0, 9));
            else
                switches_raw = 10'($urandom);
            hold = $urandom_range(1, 10);
            for (int i = 0; i < hold; i++) begin
                update_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        update_ack = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
